playfield_tx_serializer: RTL and testbench

Transmit side of the opponent-playfield link. It captures a snapshot of the local user playfield on request and streams it as a framed, checksummed byte sequence over a valid/ready byte interface toward the network PHY. The remote board's receiver rebuilds the frame into the playfield drawn in the LAN region of the display. The block sits between the game-state logic (tile source) and the link transmitter.

---
 rtl/playfield_tx_serializer_pkg.sv | 39 +++
 rtl/playfield_tx_serializer_byte_select.sv | 29 ++
 rtl/playfield_tx_serializer.sv | 170 +++++++++++++++++
 tb/tb_playfield_tx_serializer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/playfield_tx_serializer_pkg.sv
// Shared display/link definitions: playfield geometry, tile encoding and the
// framing constants used by both the link transmitter and the receiver.
package playfield_tx_serializer_pkg;

    localparam int unsigned PLAYFIELD_ROWS = 20;
    localparam int unsigned PLAYFIELD_COLS = 10;

    // 4-bit tile code; two tiles pack into one link byte.
    typedef enum logic [3:0] {
        TILE_BLANK   = 4'd0,
        TILE_GARBAGE = 4'd1,
        TILE_GHOST   = 4'd2,
        TILE_I       = 4'd3,
        TILE_J       = 4'd4,
        TILE_L       = 4'd5,
        TILE_O       = 4'd6,
        TILE_S       = 4'd7,
        TILE_T       = 4'd8,
        TILE_Z       = 4'd9
    } tile_type_t;

    localparam logic [7:0]  LINK_FRAME_HEADER = 8'hA5;
    localparam int unsigned LINK_BODY_BYTES   = PLAYFIELD_ROWS * PLAYFIELD_COLS / 2;
    localparam int unsigned LINK_FRAME_BYTES  = LINK_BODY_BYTES + 3;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_HDR,
        TX_SEQ,
        TX_BODY,
        TX_CSUM
    } tx_state_t;

    // Even column goes in the high nibble, odd column in the low nibble.
    function automatic logic [7:0] pack_tiles(input tile_type_t hi, input tile_type_t lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/playfield_tx_serializer_byte_select.sv
// playfield_byte_select: combinational mux from a playfield snapshot and a body
// byte index to the packed body byte.
//   i_snapshot  captured playfield
//   i_byte_idx  body byte index k = row*(COLS/2) + col/2
//   o_byte      {tile[row][2c], tile[row][2c+1]}; 0 for out-of-range indices
module playfield_byte_select
    import playfield_tx_serializer_pkg::*;
#(
    parameter int unsigned ROWS  = PLAYFIELD_ROWS,
    parameter int unsigned COLS  = PLAYFIELD_COLS,
    parameter int unsigned IDX_W = $clog2(ROWS * COLS / 2)
) (
    input  tile_type_t       i_snapshot [ROWS][COLS],
    input  logic [IDX_W-1:0] i_byte_idx,
    output logic [7:0]       o_byte
);

    always_comb begin
        o_byte = 8'h00;
        for (int r = 0; r < int'(ROWS); r++) begin
            for (int c = 0; c < int'(COLS / 2); c++) begin
                if (int'(i_byte_idx) == r * int'(COLS / 2) + c) begin
                    o_byte = pack_tiles(i_snapshot[r][2*c], i_snapshot[r][2*c+1]);
                end
            end
        end
    end

endmodule

// File: rtl/playfield_tx_serializer.sv
// playfield_tx_serializer: snapshots the local playfield on request and streams
// it as A5, seq, body bytes, checksum over a valid/ready byte link.
//   clk, rst_l   clock, asynchronous active-low reset
//   playfield    live playfield, copied only when a frame starts
//   send_req     one-cycle transmit request (one-deep pending when busy)
//   tx_data/tx_valid/tx_ready  registered byte stream to the link
//   busy         frame in flight or request pending
//   frame_done   high in the cycle the checksum byte is accepted
//   seq_num      sequence number of the current/last frame
module playfield_tx_serializer
    import playfield_tx_serializer_pkg::*;
#(
    parameter int unsigned ROWS = PLAYFIELD_ROWS,
    parameter int unsigned COLS = PLAYFIELD_COLS
) (
    input  logic       clk,
    input  logic       rst_l,
    input  tile_type_t playfield [ROWS][COLS],
    input  logic       send_req,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] seq_num
);

    localparam int unsigned      BODY_BYTES    = ROWS * COLS / 2;
    localparam int unsigned      CNT_W         = $clog2(BODY_BYTES);
    localparam logic [CNT_W-1:0] LAST_BODY_IDX = CNT_W'(BODY_BYTES - 1);

    tx_state_t        r_state, w_state_next;
    logic [7:0]       r_tx_data, w_tx_data_next;
    logic             r_tx_valid, w_tx_valid_next;
    logic             r_pending, w_pending_next;
    logic [7:0]       r_csum, w_csum_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic [7:0]       r_seq, w_seq_next;
    tile_type_t       r_snap [ROWS][COLS];

    logic             w_fire;
    logic             w_start;
    logic [CNT_W-1:0] w_body_idx;
    logic [7:0]       w_body_byte;

    assign w_fire = r_tx_valid && tx_ready;

    // The byte loaded on a handshake is the one after the byte being accepted.
    assign w_body_idx = (r_state == TX_BODY) ? r_cnt + 1'b1 : '0;

    playfield_byte_select #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .IDX_W (CNT_W)
    ) u_byte_select (
        .i_snapshot (r_snap),
        .i_byte_idx (w_body_idx),
        .o_byte     (w_body_byte)
    );

    always_comb begin
        w_state_next    = r_state;
        w_tx_data_next  = r_tx_data;
        w_tx_valid_next = r_tx_valid;
        w_pending_next  = r_pending;
        w_csum_next     = r_csum;
        w_cnt_next      = r_cnt;
        w_seq_next      = r_seq;
        w_start         = 1'b0;

        if (send_req && (r_state != TX_IDLE)) begin
            w_pending_next = 1'b1;
        end

        unique case (r_state)
            TX_IDLE: begin
                if (send_req || r_pending) begin
                    w_start = 1'b1;
                end
            end
            TX_HDR: begin
                if (w_fire) begin
                    w_state_next   = TX_SEQ;
                    w_tx_data_next = r_seq;
                end
            end
            TX_SEQ: begin
                if (w_fire) begin
                    w_state_next   = TX_BODY;
                    w_tx_data_next = w_body_byte;
                    w_csum_next    = r_csum ^ r_tx_data;
                    w_cnt_next     = '0;
                end
            end
            TX_BODY: begin
                if (w_fire) begin
                    w_csum_next = r_csum ^ r_tx_data;
                    if (r_cnt == LAST_BODY_IDX) begin
                        w_state_next   = TX_CSUM;
                        w_tx_data_next = r_csum ^ r_tx_data;
                        w_cnt_next     = '0;
                    end else begin
                        w_cnt_next     = r_cnt + 1'b1;
                        w_tx_data_next = w_body_byte;
                    end
                end
            end
            TX_CSUM: begin
                if (w_fire) begin
                    // A request arriving with the checksum handshake chains directly.
                    if (send_req || r_pending) begin
                        w_start = 1'b1;
                    end else begin
                        w_state_next    = TX_IDLE;
                        w_tx_valid_next = 1'b0;
                        w_tx_data_next  = 8'h00;
                    end
                end
            end
            default: begin
                w_state_next    = TX_IDLE;
                w_tx_valid_next = 1'b0;
            end
        endcase

        if (w_start) begin
            w_state_next    = TX_HDR;
            w_tx_valid_next = 1'b1;
            w_tx_data_next  = LINK_FRAME_HEADER;
            w_seq_next      = r_seq + 8'd1;
            w_csum_next     = 8'h00;
            w_cnt_next      = '0;
            w_pending_next  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state    <= TX_IDLE;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_pending  <= 1'b0;
            r_csum     <= 8'h00;
            r_cnt      <= '0;
            r_seq      <= 8'hFF;
        end else begin
            r_state    <= w_state_next;
            r_tx_data  <= w_tx_data_next;
            r_tx_valid <= w_tx_valid_next;
            r_pending  <= w_pending_next;
            r_csum     <= w_csum_next;
            r_cnt      <= w_cnt_next;
            r_seq      <= w_seq_next;
        end
    end

    // Snapshot is pure data, only read after a frame start has loaded it.
    always_ff @(posedge clk) begin
        if (w_start) begin
            r_snap <= playfield;
        end
    end

    assign tx_data    = r_tx_data;
    assign tx_valid   = r_tx_valid;
    assign busy       = (r_state != TX_IDLE) || r_pending;
    assign frame_done = (r_state == TX_CSUM) && w_fire;
    assign seq_num    = r_seq;

endmodule

// File: tb/tb_playfield_tx_serializer.sv
// Self-checking bench for playfield_tx_serializer: a frame-level reference model
// pushes expected bytes into a scoreboard queue; a negedge monitor pops and
// compares on every accepted byte and checks valid/busy/frame_done/seq per cycle.
module tb_playfield_tx_serializer;
    import playfield_tx_serializer_pkg::*;

    localparam int ROWS  = PLAYFIELD_ROWS;
    localparam int COLS  = PLAYFIELD_COLS;
    localparam int HALF  = COLS / 2;
    localparam int BODY  = ROWS * COLS / 2;
    localparam int FRAME = BODY + 3;

    logic       clk;
    logic       rst_l;
    tile_type_t pf [ROWS][COLS];
    logic       send_req;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       frame_done;
    logic [7:0] seq_num;

    playfield_tx_serializer #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) dut (
        .clk        (clk),
        .rst_l      (rst_l),
        .playfield  (pf),
        .send_req   (send_req),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .frame_done (frame_done),
        .seq_num    (seq_num)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sbq [$];
    logic [7:0] cap [$];
    int         m_rem  = 0;
    bit         m_pend = 0;
    logic [7:0] m_seq  = 8'hFF;
    int         n_frames = 0;
    bit         rnd_ready = 0;
    int         frames_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1 tx_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Reference: a frame is the header, seq, packed body and the XOR of seq+body,
    // built from the playfield as it stands when the frame begins.
    task automatic model_start();
        logic [7:0] cs;
        logic [7:0] b;
        m_seq = m_seq + 8'd1;
        sbq.push_back(8'hA5);
        sbq.push_back(m_seq);
        cs = m_seq;
        for (int k = 0; k < BODY; k++) begin
            b = {pf[k / HALF][2 * (k % HALF)], pf[k / HALF][2 * (k % HALF) + 1]};
            sbq.push_back(b);
            cs = cs ^ b;
        end
        sbq.push_back(cs);
        m_rem  = FRAME;
        m_pend = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_l);
            if (!rst_l) begin
                sbq.delete();
                m_rem  = 0;
                m_pend = 1'b0;
                m_seq  = 8'hFF;
            end else if (m_rem == 0) begin
                if (send_req || m_pend) model_start();
            end else if (tx_ready) begin
                m_rem--;
                if (m_rem == 0) begin
                    if (send_req || m_pend) model_start();
                end else if (send_req) begin
                    m_pend = 1'b1;
                end
            end else if (send_req) begin
                m_pend = 1'b1;
            end
        end
    end

    bit         prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_l) begin
                check("tx_valid", 32'(tx_valid), 32'(m_rem > 0));
                check("busy", 32'(busy), 32'((m_rem > 0) || m_pend));
                check("frame_done", 32'(frame_done), 32'((m_rem == 1) && tx_ready));
                check("seq_num", 32'(seq_num), 32'(m_seq));
                if (prev_stall) begin
                    check("stall_hold_data", 32'(tx_data), 32'(prev_data));
                    check("stall_hold_valid", 32'(tx_valid), 32'd1);
                end
                if (tx_valid && tx_ready) begin
                    if (sbq.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL sb_byte: got %0h, required no byte (queue empty)", tx_data);
                    end else begin
                        check("sb_byte", 32'(tx_data), 32'(sbq.pop_front()));
                    end
                    cap.push_back(tx_data);
                    if (frame_done) n_frames++;
                end
                prev_stall = tx_valid && !tx_ready;
                prev_data  = tx_data;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    task automatic pulse_req();
        @(posedge clk);
        #1 send_req = 1'b1;
        @(posedge clk);
        #1 send_req = 1'b0;
        frames_total++;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        for (n = 0; n < budget; n++) begin
            @(negedge clk);
            if (!busy) break;
        end
        if (n == budget) check("wait_idle_timeout", 32'(n), 32'd0);
    endtask

    task automatic wait_done(input int budget);
        int n;
        for (n = 0; n < budget; n++) begin
            @(negedge clk);
            if (frame_done) break;
        end
        if (n == budget) check("wait_done_timeout", 32'(n), 32'd0);
    endtask

    task automatic set_pf_blank();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) pf[r][c] = TILE_BLANK;
    endtask

    task automatic set_pf_random();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) pf[r][c] = tile_type_t'($urandom_range(0, 9));
    endtask

    initial begin
        int n;
        int f0;
        rst_l    = 1'b0;
        send_req = 1'b0;
        set_pf_blank();

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_seq_num", 32'(seq_num), 32'hFF);
        #1 rst_l = 1'b1;
        repeat (2) @(posedge clk);

        // Blank frame, ready high: frame_done 103 cycles after the request edge
        cap.delete();
        @(posedge clk);
        #1 send_req = 1'b1;
        @(posedge clk);
        #1 send_req = 1'b0;
        frames_total++;
        for (n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (frame_done) break;
        end
        check("frame_done_cycle", 32'(n), 32'd103);
        @(negedge clk);
        check("busy_after_frame", 32'(busy), 32'd0);
        check("blank_len", 32'(cap.size()), 32'(FRAME));
        check("blank_csum", 32'(cap[FRAME-1]), 32'h00);

        // Directed pattern, second frame
        pf[0][0]         = TILE_I;
        pf[0][1]         = TILE_Z;
        pf[ROWS-1][COLS-1] = TILE_GARBAGE;
        cap.delete();
        pulse_req();
        wait_idle(400);
        check("pat_hdr", 32'(cap[0]), 32'hA5);
        check("pat_seq", 32'(cap[1]), 32'h01);
        check("pat_body0", 32'(cap[2]), 32'h39);
        check("pat_body99", 32'(cap[FRAME-2]), 32'h01);
        check("pat_csum", 32'(cap[FRAME-1]), 32'h39);

        // Random backpressure with the playfield changed mid-frame
        rnd_ready = 1'b1;
        pulse_req();
        repeat (30) @(posedge clk);
        #1 set_pf_random();
        wait_idle(1000);
        rnd_ready = 1'b0;
        @(posedge clk);

        // Three requests during a frame plus one on the checksum handshake
        f0 = n_frames;
        pulse_req();
        repeat (10) @(posedge clk);
        repeat (3) begin
            pulse_req();
            frames_total--;
            repeat (5) @(posedge clk);
        end
        frames_total++;
        wait_done(400);
        send_req = 1'b1;
        @(posedge clk);
        #1 send_req = 1'b0;
        wait_idle(400);
        check("collapse_frames", 32'(n_frames - f0), 32'd2);

        // Only a request coinciding with the checksum handshake
        f0 = n_frames;
        pulse_req();
        wait_done(400);
        send_req = 1'b1;
        @(posedge clk);
        #1 send_req = 1'b0;
        frames_total++;
        @(negedge clk);
        check("chain_hdr_next_cycle", 32'(tx_data), 32'hA5);
        check("chain_busy", 32'(busy), 32'd1);
        wait_idle(400);
        check("chain_frames", 32'(n_frames - f0), 32'd2);

        // 256 frames: seq wraps through FF to 00 and lands where it started
        rnd_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            set_pf_random();
            pulse_req();
            wait_idle(1000);
        end
        rnd_ready = 1'b0;
        check("seq_after_wrap", 32'(seq_num), 32'(8'(frames_total - 1)));

        // Reset asserted while body byte 50 is on the bus
        cap.delete();
        pulse_req();
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            #1;
            if (cap.size() == 53) break;
        end
        check("reached_body50", 32'(cap.size()), 32'd53);
        rst_l = 1'b0;
        #1;
        check("rst_async_valid", 32'(tx_valid), 32'd0);
        check("rst_async_busy", 32'(busy), 32'd0);
        check("rst_async_seq", 32'(seq_num), 32'hFF);
        repeat (3) @(posedge clk);
        #1 rst_l = 1'b1;
        cap.delete();
        pulse_req();
        wait_idle(400);
        check("post_rst_len", 32'(cap.size()), 32'(FRAME));
        check("post_rst_hdr", 32'(cap[0]), 32'hA5);
        check("post_rst_seq", 32'(cap[1]), 32'h00);
        check("sb_drained", 32'(sbq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
